// File: rtl/byte_to_word_assembler.sv
// byte_to_word_assembler
//   Collects bytes strobed in from the UART receiver and assembles them into
//   N-bit words, most significant byte first. Each finished word is presented
//   through a one-entry valid/ready output buffer. A word that completes while
//   the buffer is still full (and not being drained) is dropped and flagged
//   with a one-cycle overrun pulse.
//
//   Optional feature macro: BYTE_TIMEOUT_EN
//     When defined, a partial word is discarded after TIMEOUT_CYCLES idle
//     cycles between bytes, and timeout pulses for one cycle. When undefined,
//     a partial word persists until it is completed or reset, and timeout is 0.
//
// Ports
//   clk         in   system clock, posedge
//   reset       in   asynchronous active-high reset
//   rx_valid    in   one-cycle byte strobe from the UART receiver
//   rx_byte     in   received byte, sampled when rx_valid=1
//   word_ready  in   consumer accepts word_out when high with word_valid
//   word_out    out  assembled word, stable while word_valid=1
//   word_valid  out  word_out holds an unconsumed word
//   busy        out  a partial word is in progress
//   overrun     out  one-cycle pulse: completed word dropped, buffer full
//   timeout     out  one-cycle pulse: partial word discarded on idle timeout
module byte_to_word_assembler #(
  parameter int N              = 16,
  parameter int CNT_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  input  logic         word_ready,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  output logic         busy,
  output logic         overrun,
  output logic         timeout
);

  localparam int               BYTES = N / 8;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0] r_byte_count;
  // Only the first BYTES-1 bytes need storing; the final byte is taken
  // straight from rx_byte on the completion cycle.
  logic [N-9:0]     r_shift;

  logic [N-1:0]     w_word;
  logic             w_complete;
  logic             w_load;
  logic             w_expire;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_word     = {r_shift, rx_byte};
  assign w_complete = rx_valid && (r_byte_count == LAST);
  // The buffer can take a new word if it is empty or is being drained now.
  assign w_load     = w_complete && (!word_valid || word_ready);

`ifdef BYTE_TIMEOUT_EN
  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] r_idle;

  // A byte arriving on the expiry cycle wins: no timeout in that case.
  assign w_expire = !rx_valid && (r_byte_count != '0) && (r_idle == IDLE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if (rx_valid || (r_byte_count == '0) || w_expire) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  // No idle timer in this build; the expression is always false.
  assign w_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_cnt_nxt = r_byte_count;
    if (rx_valid) begin
      w_cnt_nxt = w_complete ? '0 : r_byte_count + 1'b1;
    end else if (w_expire) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_count <= '0;
      r_shift      <= '0;
      busy         <= 1'b0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_byte_count <= w_cnt_nxt;
      // busy mirrors the next counter value so it equals byte_count != 0.
      busy         <= (w_cnt_nxt != '0);
      overrun      <= w_complete && word_valid && !word_ready;
      timeout      <= w_expire;

      if (rx_valid) begin
        r_shift <= w_word[N-9:0];
      end else if (w_expire) begin
        r_shift <= '0;
      end

      if (w_load) begin
        word_out   <= w_word;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/byte_to_word_assembler.md
Name: byte_to_word_assembler

Overview:
Receive-side counterpart of the word-to-byte serializer. Collects bytes strobed in from the UART receiver and assembles them into N-bit words, most significant byte first. Presents each finished word to the consumer (RSA core operand loader) through a one-entry valid/ready output buffer. Flags overruns when a word completes while the buffer is still full.

Parameters:
N, 16, word width in bits; multiple of 8, at least 16; BYTES = N/8 (localparam).
CNT_W, 2, width of the byte counter; must satisfy 2**CNT_W >= BYTES.
TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes of one word (used only with BYTE_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
rx_valid  input  1  one-cycle strobe from the UART receiver; each high cycle is one byte.
rx_byte  input  8  received byte; sampled when rx_valid=1.
word_ready  input  1  consumer accepts word_out when high together with word_valid.
word_out  output  N  assembled word; stable while word_valid=1.
word_valid  output  1  word_out holds an unconsumed word.
busy  output  1  a partial word is in progress (byte_count != 0).
overrun  output  1  one-cycle pulse: completed word dropped because buffer full.
timeout  output  1  one-cycle pulse: partial word discarded on inter-byte timeout; constant 0 without BYTE_TIMEOUT_EN.

Behaviour:
- Reset (async, any time, including mid-word): byte_count=0, shift_reg=0, word_out=0, word_valid=0, overrun=0, timeout=0, idle counter=0. Partial word lost.
- Assembly: on rx_valid, shift_reg <= {shift_reg[N-9:0], rx_byte}; byte_count increments. The first byte of a word lands in bits [N-1:N-8] of the final word.
- Completion: rx_valid while byte_count == BYTES-1 means the word is complete. byte_count wraps to 0 in the same cycle.
- Output buffer, evaluated on the completion cycle t:
  - Buffer free (word_valid=0), or being drained this cycle (word_valid & word_ready): word_out <= {shift_reg[N-9:0], rx_byte} and word_valid=1 at t+1. Latency from the last byte strobe is 1 cycle.
  - Buffer full and not drained: the new word is dropped, word_out is unchanged, and overrun=1 at t+1 for one cycle.
- Drain: word_valid & word_ready at cycle t gives word_valid=0 at t+1, unless a simultaneous completion reloads it per the rule above.
- word_out is not cleared on drain; it holds the last value.
- busy is registered and equals (byte_count != 0).
- Back-to-back rx_valid on consecutive cycles is legal; every cycle counts as a byte.
- overrun and timeout are single-cycle pulses and never sticky.
- Counter arithmetic is modulo BYTES. byte_count never reaches BYTES.

Optional Feature:
BYTE_TIMEOUT_EN
- Defined:
  - An idle counter (width clog2(TIMEOUT_CYCLES)+1) clears on every rx_valid and on every cycle with byte_count == 0.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle: byte_count <= 0, shift_reg <= 0, idle counter <= 0, and timeout pulses at the next cycle.
  - rx_valid on the expiry cycle takes priority; the byte is accepted and no timeout occurs.
  - The output buffer is unaffected by a timeout.
- Undefined: no idle counter. A partial word persists until completed or reset. timeout is tied 0.

Test Plan:
1. Basic assembly (N=16, word_ready=1): rx_byte 0xAB then 0xCD, 3 idle cycles apart.
   - Expect word_out=0xABCD and word_valid=1 one cycle after the 0xCD strobe, for exactly one cycle.
   - Expect busy=1 between the two bytes.
2. Hold and overrun (word_ready=0): send 0x1234 then 0x5678.
   - Expect word_out to stay 0x1234 with word_valid held high.
   - Expect overrun to pulse once, the cycle after the 0x78 strobe.
   - Raising word_ready then gives word_valid=0 the next cycle.
3. Simultaneous drain and complete: word_valid=1 holding 0x1111, with word_ready=1 in the same cycle as the final byte of 0x2222.
   - Expect word_out=0x2222 and word_valid=1 next cycle.
   - Expect no overrun.
4. Reset mid-word: send 0xAA, assert reset asynchronously (mid-cycle), release, then send 0xBB, 0xCC.
   - Expect all outputs 0 during reset.
   - Expect the next word to be 0xBBCC, with no trace of 0xAA.
5. Back-to-back, N=32: bytes 0xDE, 0xAD, 0xBE, 0xEF on consecutive cycles.
   - Expect word_out=0xDEADBEEF one cycle after the 0xEF strobe.
   - Expect busy to drop to 0 that same cycle.
6. BYTE_TIMEOUT_EN, TIMEOUT_CYCLES=8: send 0x12, wait 10 cycles, then send 0x34, 0x56.
   - Expect a timeout pulse after the 8th idle cycle, with busy returning to 0.
   - Expect the resulting word to be 0x3456.
